// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding data-memory transaction per accepted
// load or store, with alignment checking, lane steering and load-data extension.
module lsu_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_is_store_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic [4:0]      resp_rd_o,
  output logic            resp_we_o,
  output logic            resp_misaligned_o,
  output logic            resp_err_o,
  output logic [XLEN-1:0] resp_addr_o,
  output logic            dmem_req_o,
  input  logic            dmem_gnt_i,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [7:0]      dmem_be_o,
  output logic [63:0]     dmem_wdata_o,
  input  logic            dmem_rvalid_i,
  input  logic [63:0]     dmem_rdata_i,
  input  logic            dmem_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
    return is_store ? f3[2] : (f3 == 3'b111);
  endfunction

  // Size code in f3[1:0]: 0=byte, 1=half, 2=word, 3=double.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic m;
    case (sz)
      2'd0:    m = 1'b0;
      2'd1:    m = off[0];
      2'd2:    m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] byte_en(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] replicate(input logic [1:0] sz, input logic [63:0] d);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {8{d[7:0]}};
      2'd1:    r = {4{d[15:0]}};
      2'd2:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [63:0] raw,
                                           input logic [2:0] off);
    logic [63:0] sh;
    logic [63:0] r;
    sh = raw >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{56{sh[7]}}, sh[7:0]};
      3'b001:  r = {{48{sh[15]}}, sh[15:0]};
      3'b010:  r = {{32{sh[31]}}, sh[31:0]};
      3'b011:  r = sh;
      3'b100:  r = {56'd0, sh[7:0]};
      3'b101:  r = {48'd0, sh[15:0]};
      3'b110:  r = {32'd0, sh[31:0]};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              killed_q, killed_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
  logic [7:0]        dmem_be_q, dmem_be_d;
  logic [63:0]       dmem_wdata_q, dmem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic              resp_we_q, resp_we_d;
  logic              resp_mis_q, resp_mis_d;
  logic              resp_err_q, resp_err_d;
  logic [XLEN-1:0]   resp_addr_q, resp_addr_d;

  assign req_ready_o = (state_q == S_IDLE) && !flush_i;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    killed_d     = killed_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_we_d    = resp_we_q;
    resp_mis_d   = resp_mis_q;
    resp_err_d   = resp_err_q;
    resp_addr_d  = resp_addr_q;

    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        if (req_valid_i && req_ready_o) begin
          is_store_d = req_is_store_i;
          funct3_d   = req_funct3_i;
          addr_d     = req_addr_i;
          rd_d       = req_rd_i;
          if (is_illegal(req_is_store_i, req_funct3_i) ||
              is_misaligned(req_funct3_i[1:0], req_addr_i[2:0])) begin
            // Exceptions answer directly without touching memory.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = {XLEN{1'b0}};
            resp_rd_d    = req_rd_i;
            resp_we_d    = 1'b0;
            resp_err_d   = is_illegal(req_is_store_i, req_funct3_i);
            resp_mis_d   = !is_illegal(req_is_store_i, req_funct3_i);
            resp_addr_d  = req_addr_i;
          end else begin
            state_d      = S_REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = req_is_store_i;
            dmem_addr_d  = {req_addr_i[XLEN-1:3], 3'b000};
            dmem_be_d    = byte_en(req_funct3_i[1:0], req_addr_i[2:0]);
            dmem_wdata_d = replicate(req_funct3_i[1:0], req_wdata_i);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        killed_d = killed_q | flush_i;
        if (dmem_gnt_i) begin
          state_d      = S_WAIT;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_addr_d  = {XLEN{1'b0}};
          dmem_be_d    = 8'h00;
          dmem_wdata_d = 64'd0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          if (killed_q || flush_i) begin
            state_d  = S_IDLE;
            killed_d = 1'b0;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = (dmem_err_i || is_store_q) ? {XLEN{1'b0}}
                                                      : load_ext(funct3_q, dmem_rdata_i, addr_q[2:0]);
            resp_rd_d    = rd_q;
            resp_we_d    = !is_store_q && !dmem_err_i;
            resp_mis_d   = 1'b0;
            resp_err_d   = dmem_err_i;
            resp_addr_d  = addr_q;
          end
        end else begin
          killed_d = killed_q | flush_i;
        end
      end
      S_RESP: begin
        if (resp_ready_i || flush_i) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = {XLEN{1'b0}};
          resp_rd_d    = 5'd0;
          resp_we_d    = 1'b0;
          resp_mis_d   = 1'b0;
          resp_err_d   = 1'b0;
          resp_addr_d  = {XLEN{1'b0}};
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      killed_q     <= 1'b0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= {XLEN{1'b0}};
      rd_q         <= 5'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= {XLEN{1'b0}};
      dmem_be_q    <= 8'h00;
      dmem_wdata_q <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {XLEN{1'b0}};
      resp_rd_q    <= 5'd0;
      resp_we_q    <= 1'b0;
      resp_mis_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_addr_q  <= {XLEN{1'b0}};
    end else begin
      state_q      <= state_d;
      killed_q     <= killed_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_we_q    <= resp_we_d;
      resp_mis_q   <= resp_mis_d;
      resp_err_q   <= resp_err_d;
      resp_addr_q  <= resp_addr_d;
    end
  end

  assign dmem_req_o        = dmem_req_q;
  assign dmem_we_o         = dmem_we_q;
  assign dmem_addr_o       = dmem_addr_q;
  assign dmem_be_o         = dmem_be_q;
  assign dmem_wdata_o      = dmem_wdata_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_rdata_o      = resp_rdata_q;
  assign resp_rd_o         = resp_rd_q;
  assign resp_we_o         = resp_we_q;
  assign resp_misaligned_o = resp_mis_q;
  assign resp_err_o        = resp_err_q;
  assign resp_addr_o       = resp_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed scenarios plus randomized loads/stores checked
// against a byte-level reference model of the load/store rules.
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_is_store_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'd0;
  logic [63:0] req_addr_i = 64'd0, req_wdata_i = 64'd0;
  logic [4:0]  req_rd_i = 5'd0;
  logic        flush_i = 1'b0, resp_ready_i = 1'b0;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0, dmem_err_i = 1'b0;
  logic [63:0] dmem_rdata_i = 64'd0;
  logic        req_ready_o, resp_valid_o, resp_we_o, resp_misaligned_o, resp_err_o;
  logic [63:0] resp_rdata_o, resp_addr_o, dmem_addr_o, dmem_wdata_o;
  logic [4:0]  resp_rd_o;
  logic        dmem_req_o, dmem_we_o;
  logic [7:0]  dmem_be_o;

  int vectors = 0;
  int miscompares = 0;

  lsu_ctrl #(.XLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_is_store_i(req_is_store_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i), .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
    .resp_rd_o(resp_rd_o), .resp_we_o(resp_we_o), .resp_misaligned_o(resp_misaligned_o),
    .resp_err_o(resp_err_o), .resp_addr_o(resp_addr_o),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          req;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    bit          mis;
    bit          err;
    logic [63:0] rdata;
    bit          we;
  } exp_t;

  // Reference: derived from access size in bytes and plain address arithmetic.
  function automatic exp_t model(bit st, bit [2:0] f3, logic [63:0] a, logic [63:0] wd,
                                 logic [63:0] mrd, bit berr);
    exp_t e;
    int size, off;
    bit illegal;
    logic [63:0] v, mask;
    size = 1 << f3[1:0];
    off = int'(a % 64'd8);
    illegal = st ? f3[2] : (f3 == 3'd7);
    e.mis = !illegal && ((a % size) != 0);
    e.req = !illegal && !e.mis;
    e.addr = a - (a % 64'd8);
    e.be = 8'(((1 << size) - 1) << off);
    for (int i = 0; i < 8; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*size)) - 64'd1);
    v = (mrd >> (8*off)) & mask;
    if (!f3[2] && size < 8 && v[8*size-1]) v = v | ~mask;
    e.err = illegal || (e.req && berr);
    e.we = e.req && !st && !berr;
    e.rdata = e.we ? v : 64'd0;
    return e;
  endfunction

  bit          o_rdy, o_req_seen, o_req_stable, o_resp_seen, o_resp_stable, o_rdy_low, o_idle_after;
  int          o_req_cyc, o_resp_cyc;
  logic [63:0] o_addr, o_wdata, o_rdata, o_raddr;
  logic [7:0]  o_be;
  logic [4:0]  o_rrd;
  logic        o_we, o_rwe, o_rmis, o_rerr;

  // Drives one operation and plays the memory side; records observations only.
  // flush_mode: 0 none, 1 flush from first REQ cycle through the grant cycle, 2 flush with rvalid.
  task automatic run_op(input bit st, input bit [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                        input logic [4:0] rd, input int gd, input int rv, input int rdy_dly,
                        input logic [63:0] mrd, input bit berr, input int flush_mode);
    int cyc;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_is_store_i = st; req_funct3_i = f3;
    req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
    #1 o_rdy = req_ready_o;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    cyc = 1;
    o_req_seen = 0; o_resp_seen = 0; o_req_stable = 1; o_resp_stable = 1; o_rdy_low = 1;
    o_req_cyc = -1; o_resp_cyc = -1;
    for (int k = 0; k < 8 && !dmem_req_o && !resp_valid_o; k++) begin
      @(negedge clk_i); cyc++;
    end
    if (dmem_req_o) begin
      o_req_seen = 1; o_req_cyc = cyc;
      o_addr = dmem_addr_o; o_be = dmem_be_o; o_we = dmem_we_o; o_wdata = dmem_wdata_o;
      for (int k = 0; k <= gd; k++) begin
        if (flush_mode == 1) flush_i = 1'b1;
        if (dmem_req_o !== 1'b1 || dmem_addr_o !== o_addr || dmem_be_o !== o_be ||
            dmem_we_o !== o_we || dmem_wdata_o !== o_wdata) o_req_stable = 0;
        dmem_gnt_i = (k == gd);
        @(negedge clk_i); cyc++;
      end
      dmem_gnt_i = 1'b0; flush_i = 1'b0;
      for (int k = 1; k < rv; k++) begin
        @(negedge clk_i); cyc++;
      end
      dmem_rvalid_i = 1'b1; dmem_rdata_i = mrd; dmem_err_i = berr;
      flush_i = (flush_mode == 2);
      @(negedge clk_i); cyc++;
      dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; flush_i = 1'b0;
      dmem_rdata_i = {$urandom, $urandom};
    end
    for (int k = 0; k < 6 && !resp_valid_o; k++) begin
      @(negedge clk_i); cyc++;
    end
    if (resp_valid_o) begin
      o_resp_seen = 1; o_resp_cyc = cyc;
      o_rdata = resp_rdata_o; o_rrd = resp_rd_o; o_rwe = resp_we_o;
      o_rmis = resp_misaligned_o; o_rerr = resp_err_o; o_raddr = resp_addr_o;
      for (int k = 0; k < rdy_dly; k++) begin
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== o_rdata || resp_rd_o !== o_rrd ||
            resp_we_o !== o_rwe || resp_misaligned_o !== o_rmis || resp_err_o !== o_rerr ||
            resp_addr_o !== o_raddr) o_resp_stable = 0;
        if (req_ready_o !== 1'b0) o_rdy_low = 0;
        @(negedge clk_i);
      end
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      resp_ready_i = 1'b0;
    end
    o_idle_after = (resp_valid_o === 1'b0) && (req_ready_o === 1'b1) && (dmem_req_o === 1'b0);
  endtask

  task automatic test_reset();
    logic [274:0] all_out;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    all_out = {dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, resp_valid_o,
               resp_rdata_o, resp_rd_o, resp_we_o, resp_misaligned_o, resp_err_o, resp_addr_o};
    vectors++;
    if (all_out !== 275'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_lw_aligned();
    run_op(1'b0, 3'b010, 64'h1004, 64'd0, 5'd7, 0, 1, 0, 64'h8000_0001_0000_0000, 1'b0, 0);
    vectors++; if (o_rdy !== 1'b1) begin miscompares++; $display("FAIL lw_ready: got %b want 1", o_rdy); end
    vectors++; if (o_req_cyc != 1) begin miscompares++; $display("FAIL lw_req_cyc: got %0d want 1", o_req_cyc); end
    vectors++; if (o_addr !== 64'h1000) begin miscompares++; $display("FAIL lw_addr: got %h want 1000", o_addr); end
    vectors++; if (o_be !== 8'hF0) begin miscompares++; $display("FAIL lw_be: got %h want f0", o_be); end
    vectors++; if (o_resp_cyc != 3) begin miscompares++; $display("FAIL lw_latency: got %0d want 3", o_resp_cyc); end
    vectors++; if (o_rdata !== 64'hFFFF_FFFF_8000_0001) begin miscompares++; $display("FAIL lw_rdata: got %h want ffffffff80000001", o_rdata); end
    vectors++; if ({o_rwe, o_rmis, o_rerr, o_rrd} !== {3'b100, 5'd7}) begin miscompares++; $display("FAIL lw_flags: got %b want 10000111", {o_rwe, o_rmis, o_rerr, o_rrd}); end
  endtask

  task automatic test_sb_delayed_gnt();
    run_op(1'b1, 3'b000, 64'h2003, 64'h0000_0000_0000_00AB, 5'd3, 4, 1, 0, 64'd0, 1'b0, 0);
    vectors++; if (o_req_stable !== 1'b1) begin miscompares++; $display("FAIL sb_req_stable: got %b want 1", o_req_stable); end
    vectors++; if ({o_addr, o_be, o_we} !== {64'h2000, 8'h08, 1'b1}) begin miscompares++; $display("FAIL sb_req_fields: got %h %h %b want 2000 08 1", o_addr, o_be, o_we); end
    vectors++; if (o_wdata !== 64'hABAB_ABAB_ABAB_ABAB) begin miscompares++; $display("FAIL sb_wdata: got %h want abababababababab", o_wdata); end
    vectors++; if ({o_rwe, o_rdata} !== 65'd0) begin miscompares++; $display("FAIL sb_resp: got we %b rdata %h want 0 0", o_rwe, o_rdata); end
    vectors++; if (o_resp_cyc != 7) begin miscompares++; $display("FAIL sb_latency: got %0d want 7", o_resp_cyc); end
  endtask

  task automatic test_misaligned_illegal();
    run_op(1'b0, 3'b101, 64'h3001, 64'd0, 5'd9, 0, 1, 0, 64'd0, 1'b0, 0);
    vectors++; if (o_req_seen !== 1'b0) begin miscompares++; $display("FAIL mis_no_req: got %b want 0", o_req_seen); end
    vectors++; if (o_resp_cyc != 1) begin miscompares++; $display("FAIL mis_latency: got %0d want 1", o_resp_cyc); end
    vectors++; if ({o_rmis, o_rerr, o_rwe, o_raddr} !== {3'b100, 64'h3001}) begin miscompares++; $display("FAIL mis_resp: got %b%b%b %h want 100 3001", o_rmis, o_rerr, o_rwe, o_raddr); end
    run_op(1'b0, 3'b111, 64'h3000, 64'd0, 5'd9, 0, 1, 0, 64'd0, 1'b0, 0);
    vectors++; if ({o_req_seen, o_rerr, o_rmis, o_rwe} !== 4'b0100) begin miscompares++; $display("FAIL ill_load: got %b want 0100", {o_req_seen, o_rerr, o_rmis, o_rwe}); end
    run_op(1'b1, 3'b100, 64'h3000, 64'd0, 5'd9, 0, 1, 0, 64'd0, 1'b0, 0);
    vectors++; if ({o_req_seen, o_rerr, o_resp_cyc} !== {2'b01, 32'd1}) begin miscompares++; $display("FAIL ill_store: got %b%b cyc %0d want 01 cyc 1", o_req_seen, o_rerr, o_resp_cyc); end
  endtask

  task automatic test_bus_err_and_ld();
    run_op(1'b0, 3'b100, 64'h4007, 64'd0, 5'd4, 1, 2, 0, 64'hFF00_0000_0000_0000, 1'b1, 0);
    vectors++; if ({o_rerr, o_rwe, o_rdata} !== {2'b10, 64'd0}) begin miscompares++; $display("FAIL lbu_err: got %b%b %h want 10 0", o_rerr, o_rwe, o_rdata); end
    run_op(1'b0, 3'b011, 64'h4008, 64'd0, 5'd5, 0, 1, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
    vectors++; if ({o_rwe, o_rdata} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin miscompares++; $display("FAIL ld_pass: got %b %h want 1 0123456789abcdef", o_rwe, o_rdata); end
    vectors++; if (o_be !== 8'hFF) begin miscompares++; $display("FAIL ld_be: got %h want ff", o_be); end
  endtask

  task automatic test_flush();
    run_op(1'b0, 3'b010, 64'h5000, 64'd0, 5'd1, 2, 2, 0, 64'h1234_5678, 1'b0, 1);
    vectors++; if (o_req_stable !== 1'b1) begin miscompares++; $display("FAIL flush_req_held: got %b want 1", o_req_stable); end
    vectors++; if (o_resp_seen !== 1'b0) begin miscompares++; $display("FAIL flush_no_resp: got %b want 0", o_resp_seen); end
    vectors++; if (o_idle_after !== 1'b1) begin miscompares++; $display("FAIL flush_idle: got %b want 1", o_idle_after); end
    run_op(1'b0, 3'b001, 64'h5002, 64'd0, 5'd2, 0, 1, 0, 64'h0000_0000_8001_0000, 1'b0, 0);
    vectors++; if ({o_rwe, o_rdata} !== {1'b1, 64'hFFFF_FFFF_FFFF_8001}) begin miscompares++; $display("FAIL flush_next_lh: got %b %h want 1 ffffffffffff8001", o_rwe, o_rdata); end
    run_op(1'b0, 3'b011, 64'h5008, 64'd0, 5'd2, 0, 1, 0, 64'h55, 1'b0, 2);
    vectors++; if ({o_resp_seen, o_idle_after} !== 2'b01) begin miscompares++; $display("FAIL flush_with_rvalid: got %b want 01", {o_resp_seen, o_idle_after}); end
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 3'b000, 64'h6005, 64'd0, 5'd11, 0, 1, 6, 64'h0000_8000_0000_0000, 1'b0, 0);
    vectors++; if ({o_resp_stable, o_rdy_low} !== 2'b11) begin miscompares++; $display("FAIL bp_stable: got %b want 11", {o_resp_stable, o_rdy_low}); end
    vectors++; if (o_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin miscompares++; $display("FAIL bp_lb: got %h want ffffffffffffff80", o_rdata); end
    vectors++; if (o_idle_after !== 1'b1) begin miscompares++; $display("FAIL bp_idle: got %b want 1", o_idle_after); end
  endtask

  task automatic test_reset_in_wait();
    logic [274:0] all_out;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_is_store_i = 1'b0; req_funct3_i = 3'b011; req_addr_i = 64'h7000;
    @(negedge clk_i);
    req_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    all_out = {dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, resp_valid_o,
               resp_rdata_o, resp_rd_o, resp_we_o, resp_misaligned_o, resp_err_o, resp_addr_o};
    vectors++;
    if (all_out !== 275'd0) begin miscompares++; $display("FAIL rst_wait_outputs: got %h want 0", all_out); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_wait_ready: got %b want 1", req_ready_o); end
    run_op(1'b0, 3'b110, 64'h7004, 64'd0, 5'd6, 0, 1, 0, 64'h9000_0000_0000_0000, 1'b0, 0);
    vectors++; if ({o_rwe, o_rdata} !== {1'b1, 64'h0000_0000_9000_0000}) begin miscompares++; $display("FAIL rst_wait_next: got %b %h want 1 90000000", o_rwe, o_rdata); end
  endtask

  task automatic test_random();
    exp_t e;
    bit st, berr;
    bit [2:0] f3;
    logic [63:0] a, wd, mrd;
    logic [4:0] rd;
    int gd, rv, rdy, size, want_cyc;
    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 7) != 0) f3[2] = 1'b0;
      size = 1 << f3[1:0];
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a - (a % size);
      wd = {$urandom, $urandom};
      mrd = {$urandom, $urandom};
      rd = 5'($urandom_range(0, 31));
      berr = ($urandom_range(0, 7) == 0);
      gd = $urandom_range(0, 3);
      rv = $urandom_range(1, 3);
      rdy = $urandom_range(0, 2);
      e = model(st, f3, a, wd, mrd, berr);
      run_op(st, f3, a, wd, rd, gd, rv, rdy, mrd, berr, 0);
      want_cyc = e.req ? (2 + gd + rv) : 1;
      vectors++;
      if (o_req_seen !== e.req) begin miscompares++; $display("FAIL rnd_req op%0d: got %b want %b", i, o_req_seen, e.req); end
      if (e.req) begin
        vectors++;
        if ({o_addr, o_be, o_we} !== {e.addr, e.be, st}) begin miscompares++; $display("FAIL rnd_dmem op%0d: got %h %h %b want %h %h %b", i, o_addr, o_be, o_we, e.addr, e.be, st); end
        vectors++;
        if (st && o_wdata !== e.wdata) begin miscompares++; $display("FAIL rnd_wdata op%0d: got %h want %h", i, o_wdata, e.wdata); end
      end
      vectors++;
      if (o_resp_cyc != want_cyc) begin miscompares++; $display("FAIL rnd_latency op%0d: got %0d want %0d", i, o_resp_cyc, want_cyc); end
      vectors++;
      if (o_rdata !== e.rdata) begin miscompares++; $display("FAIL rnd_rdata op%0d: got %h want %h", i, o_rdata, e.rdata); end
      vectors++;
      if ({o_rwe, o_rmis, o_rerr, o_rrd, o_raddr} !== {e.we, e.mis, e.err, rd, a}) begin miscompares++; $display("FAIL rnd_resp op%0d: got %b%b%b %h %h want %b%b%b %h %h", i, o_rwe, o_rmis, o_rerr, o_rrd, o_raddr, e.we, e.mis, e.err, rd, a); end
      vectors++;
      if ({o_resp_stable, o_idle_after} !== 2'b11) begin miscompares++; $display("FAIL rnd_handshake op%0d: got %b want 11", i, {o_resp_stable, o_idle_after}); end
    end
  endtask

  initial begin
    test_reset();
    test_lw_aligned();
    test_sb_delayed_gnt();
    test_misaligned_illegal();
    test_bus_err_and_ld();
    test_flush();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller for the RV64I core: accepts one decoded load or store from execute, checks alignment, and sequences a single request/grant/response transaction on the data-memory port. It builds byte enables and replicated write data, then extracts and sign- or zero-extends load data. It returns one response per accepted operation to writeback. At most one memory transaction is outstanding.

## Interface
- XLEN, 64, register and address width; the data bus is fixed at 64 bits.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  operation offered by execute
- req_ready_o  out  1  operation accepted when valid&ready
- req_is_store_i  in  1  1 = store (funct3 decoded as func_store_t), 0 = load (func_load_t)
- req_funct3_i  in  3  load/store funct3
- req_addr_i  in  XLEN  effective address (rs1+imm)
- req_wdata_i  in  XLEN  rs2 value
- req_rd_i  in  5  destination register index
- flush_i  in  1  kill in-flight operation
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  writeback accepts response
- resp_rdata_o  out  XLEN  extended load data; 0 for stores
- resp_rd_o  out  5  destination index
- resp_we_o  out  1  regfile write enable: load and no exception
- resp_misaligned_o  out  1  address misaligned for access size
- resp_err_o  out  1  bus error or illegal funct3
- resp_addr_o  out  XLEN  faulting/effective address (for mtval)
- dmem_req_o  out  1  memory request
- dmem_gnt_i  in  1  memory grant
- dmem_we_o  out  1  write
- dmem_addr_o  out  XLEN  doubleword-aligned address, bits [2:0]=0
- dmem_be_o  out  8  byte enables
- dmem_wdata_o  out  64  write data
- dmem_rvalid_i  in  1  response valid (at least 1 cycle after gnt)
- dmem_rdata_i  in  64  read data
- dmem_err_i  in  1  bus error, qualified by rvalid

## Operation
- States: IDLE, REQ, WAIT, RESP, plus a sticky killed flag.
- IDLE: req_ready_o = !flush_i (combinational). On accept, capture all req_* fields and decode.
  - Illegal funct3 (load 3'b111; store funct3[2]=1): go to RESP with resp_err_o=1, no memory access.
  - Misaligned (H/HU/SH: addr[0]≠0; W/WU/SW: addr[1:0]≠0; D/SD: addr[2:0]≠0): go to RESP with resp_misaligned_o=1, no memory access.
  - Otherwise go to REQ.
- REQ: dmem_req_o=1. Address, we, be and wdata are held stable until dmem_gnt_i. Go to WAIT on the gnt cycle.
- WAIT: on dmem_rvalid_i, capture rdata/err. Go to RESP, or to IDLE if killed.
- RESP: resp_valid_o=1 with all resp_* stable until resp_ready_i. Then go to IDLE.
- Byte enables: size mask (1/3/F/FF) shifted left by addr[2:0].
- Write data replication: byte ×8, half ×4, word ×2, double as-is.
- Load data: rdata >> (8·addr[2:0]), then truncate to size. LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend; LD passes through.
- On error, resp_rdata_o=0 and resp_we_o=0.
- Flush handling:
  - IDLE: nothing is accepted.
  - REQ: set killed; the request stays asserted until gnt (no retraction).
  - WAIT: set killed; rvalid is absorbed silently.
  - RESP: resp_valid_o drops next cycle and the state goes to IDLE.
  - killed clears on entry to IDLE.
- flush_i and rvalid in the same WAIT cycle: the response is discarded and the state goes to IDLE.

## Timing
- Reset (async assert, sync-release behaviour on clk_i): state IDLE, killed=0. All registered outputs are 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_we_o, resp_misaligned_o, resp_err_o, resp_addr_o.
- req_ready_o=1 while in reset-released IDLE with flush_i=0.
- Reset mid-transaction returns to IDLE immediately. The memory side is reset by the same rst_ni.
- Accept at cycle 0 → dmem_req_o high cycle 1.
- gnt in cycle 1 → WAIT in cycle 2. rvalid in cycle 2 → resp_valid_o high cycle 3. Minimum aligned latency is 3 cycles.
- Misaligned or illegal accept at cycle 0 → resp_valid_o high cycle 1.
- All dmem_* and resp_* outputs are registered; only req_ready_o is combinational.
- Back-to-back throughput: a new accept can occur the cycle after the resp handshake.

## Test plan
- Aligned LW, addr 0x1004, rdata 0x8000_0001_0000_0000, gnt immediate, rvalid next cycle → dmem_addr 0x1000, be 0xF0, resp_rdata 0xFFFF_FFFF_8000_0001, resp_we 1, resp_valid at cycle 3.
- SB, addr 0x2003, rs2 0xAB, gnt delayed 4 cycles → req/addr/be 0x08/wdata 0xABAB…AB held stable all 5 cycles, resp_we 0.
- LHU at 0x3001 → no dmem_req, resp_valid at cycle 1, resp_misaligned 1, resp_addr 0x3001; load funct3 3'b111 → resp_err 1, no dmem_req.
- LBU at 0x4007 with dmem_err 1 → resp_err 1, rdata 0, we 0. LD at 0x4008 with data 0x0123_4567_89AB_CDEF → passed through unchanged.
- flush_i asserted in REQ and held until after gnt → request stays up until gnt, rvalid absorbed, no resp_valid, state IDLE, next load completes normally.
- resp_ready_i held low 6 cycles → resp_* stable and req_ready_o 0 throughout. Reset asserted in WAIT → all outputs 0 immediately, req_ready_o 1 after release.
